// File: rtl/equiv_stim_pkg.sv
// Shared types and constants for the equivalence stimulus generator.
//
// Contents:
//   state_e        run-control FSM states
//   LfsrPoly       Galois polynomial for every LFSR lane (shift right)
//   SeedXor1/2     scramble constants that derive lane 1/2 seeds from the user seed
//   Wire*Off/W     bit offset and width of each stimulus port in the 84-bit vector
//   StimW          total stimulus width
//   lfsr_next()    one Galois step
package equiv_stim_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam logic [31:0] LfsrPoly = 32'h8020_0003;
  localparam logic [31:0] SeedXor1 = 32'h9E37_79B9;
  localparam logic [31:0] SeedXor2 = 32'h7F4A_7C15;

  localparam int unsigned Wire0Off = 0;
  localparam int unsigned Wire0W   = 19;
  localparam int unsigned Wire1Off = 19;
  localparam int unsigned Wire1W   = 20;
  localparam int unsigned Wire2Off = 39;
  localparam int unsigned Wire2W   = 18;
  localparam int unsigned Wire3Off = 57;
  localparam int unsigned Wire3W   = 12;
  localparam int unsigned Wire4Off = 69;
  localparam int unsigned Wire4W   = 15;

  localparam int unsigned StimW = 84;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) begin
      r = r ^ LfsrPoly;
    end
    return r;
  endfunction

endpackage

// File: rtl/equiv_lfsr32.sv
// One 32-bit Galois LFSR lane (shift right, polynomial LfsrPoly).
//
// Ports:
//   clk_i    clock
//   rst_i    asynchronous reset, active-high
//   load_i   load seed_i (a zero seed is replaced by 1 so the lane never locks up)
//   en_i     advance one step
//   seed_i   seed value
//   state_o  low OutW bits of the current lane state
module equiv_lfsr32
  import equiv_stim_pkg::*;
#(
  parameter int unsigned OutW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [31:0]     seed_i,
  output logic [OutW-1:0] state_o
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == 32'h0) ? 32'h1 : seed_i;
    end else if (en_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= 32'h1;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q[OutW-1:0];

endmodule

// File: rtl/equiv_stim_gen.sv
// Self-checking stimulus source for a two-copy equivalence harness.
// Drives LFSR vectors onto wire0..wire4 for num_vectors cycles, compares y_1 against y_2
// PIPE_DEPTH cycles later, and reports pass, a saturating mismatch count and the index of
// the first failing vector.
//
// Optional feature: define EQUIV_STIM_SNAPSHOT_EN to keep a PIPE_DEPTH-deep history of
// issued vectors and capture the vector behind the first failure in fail_snapshot.
// Without it, fail_snapshot is tied to 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begin a run (accepted in IDLE/DONE only)
//   seed, num_vectors        run configuration, captured on an accepted start
//   y_1, y_2                 outputs of the two design copies
//   wire0..wire4             stimulus slices of the 84-bit vector
//   busy, done, pass         run status (pass valid while done)
//   mismatch_cnt             saturating failing-compare count
//   first_fail_idx           index of first failing vector, all-ones if none
//   fail_snapshot            stimulus of the first failing vector
module equiv_stim_gen
  import equiv_stim_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned YW         = 91,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        seed,
  input  logic [CNT_W-1:0]   num_vectors,
  input  logic [YW-1:0]      y_1,
  input  logic [YW-1:0]      y_2,
  output logic [Wire0W-1:0]  wire0,
  output logic [Wire1W-1:0]  wire1,
  output logic [Wire2W-1:0]  wire2,
  output logic [Wire3W-1:0]  wire3,
  output logic [Wire4W-1:0]  wire4,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [CNT_W-1:0]   first_fail_idx,
  output logic [StimW-1:0]   fail_snapshot
);

  state_e state_q, state_d;

  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
  logic [3:0]       drain_q, drain_d;
  logic [StimW-1:0] stim_q, stim_d;
  logic [CNT_W-1:0] mismatch_q, mismatch_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;

  // Issue flag and vector index travel together so each compare knows which vector it checks.
  logic [PIPE_DEPTH-1:0] valid_sr_q, valid_sr_d;
  logic [CNT_W-1:0]      idx_sr_q [PIPE_DEPTH];
  logic [CNT_W-1:0]      idx_sr_d [PIPE_DEPTH];

  logic             accept;
  logic             issue;
  logic             cmp_fail;
  logic             first_fail;
  logic [31:0]      lane0, lane1;
  logic [StimW-65:0] lane2;
  logic [StimW-1:0] stim_next;

  assign accept     = start && ((state_q == StIdle) || (state_q == StDone));
  assign issue      = (state_q == StRun);
  assign cmp_fail   = valid_sr_q[PIPE_DEPTH-1] && (y_1 != y_2);
  assign first_fail = cmp_fail && (mismatch_q == '0);

  // Lane 2 only needs its low 20 bits; bits 95:84 of the bank are never driven out.
  equiv_lfsr32 #(
    .OutW(32)
  ) u_lane0 (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (accept),
    .en_i   (issue),
    .seed_i (seed),
    .state_o(lane0)
  );

  equiv_lfsr32 #(
    .OutW(32)
  ) u_lane1 (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (accept),
    .en_i   (issue),
    .seed_i (seed ^ SeedXor1),
    .state_o(lane1)
  );

  equiv_lfsr32 #(
    .OutW(StimW - 64)
  ) u_lane2 (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (accept),
    .en_i   (issue),
    .seed_i (seed ^ SeedXor2),
    .state_o(lane2)
  );

  assign stim_next = {lane2, lane1, lane0};

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = (num_vectors == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (vec_idx_q == num_q - CNT_W'(1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Last compare lands PIPE_DEPTH edges after the final issue; leave one edge later.
        if (drain_q == 4'(PIPE_DEPTH)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    num_d       = num_q;
    vec_idx_d   = vec_idx_q;
    drain_d     = (state_q == StDrain) ? drain_q + 4'd1 : 4'd0;
    stim_d      = stim_q;
    mismatch_d  = mismatch_q;
    first_idx_d = first_idx_q;

    if (accept) begin
      num_d       = num_vectors;
      vec_idx_d   = '0;
      mismatch_d  = '0;
      first_idx_d = '1;
    end else begin
      if (issue) begin
        vec_idx_d = vec_idx_q + CNT_W'(1);
        stim_d    = stim_next;
      end
      if (cmp_fail && !(&mismatch_q)) begin
        mismatch_d = mismatch_q + CNT_W'(1);
      end
      if (first_fail) begin
        first_idx_d = idx_sr_q[PIPE_DEPTH-1];
      end
    end
  end

  always_comb begin
    valid_sr_d    = valid_sr_q;
    idx_sr_d      = idx_sr_q;
    valid_sr_d[0] = issue;
    idx_sr_d[0]   = vec_idx_q;
    for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
      valid_sr_d[i] = valid_sr_q[i-1];
      idx_sr_d[i]   = idx_sr_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      num_q       <= '0;
      vec_idx_q   <= '0;
      drain_q     <= '0;
      stim_q      <= '0;
      mismatch_q  <= '0;
      first_idx_q <= '1;
      valid_sr_q  <= '0;
      for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
        idx_sr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      vec_idx_q   <= vec_idx_d;
      drain_q     <= drain_d;
      stim_q      <= stim_d;
      mismatch_q  <= mismatch_d;
      first_idx_q <= first_idx_d;
      valid_sr_q  <= valid_sr_d;
      idx_sr_q    <= idx_sr_d;
    end
  end

`ifdef EQUIV_STIM_SNAPSHOT_EN
  // History runs in lockstep with valid_sr_q, so the last entry is the vector under compare.
  logic [StimW-1:0] hist_q [PIPE_DEPTH];
  logic [StimW-1:0] hist_d [PIPE_DEPTH];
  logic [StimW-1:0] snap_q, snap_d;

  always_comb begin
    hist_d    = hist_q;
    hist_d[0] = stim_next;
    for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
      hist_d[i] = hist_q[i-1];
    end
    snap_d = snap_q;
    if (accept) begin
      snap_d = '0;
    end else if (first_fail) begin
      snap_d = hist_q[PIPE_DEPTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
      for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      snap_q <= snap_d;
      hist_q <= hist_d;
    end
  end

  assign fail_snapshot = snap_q;
`else
  assign fail_snapshot = '0;
`endif

  assign wire0          = stim_q[Wire0Off +: Wire0W];
  assign wire1          = stim_q[Wire1Off +: Wire1W];
  assign wire2          = stim_q[Wire2Off +: Wire2W];
  assign wire3          = stim_q[Wire3Off +: Wire3W];
  assign wire4          = stim_q[Wire4Off +: Wire4W];
  assign busy           = (state_q == StRun) || (state_q == StDrain);
  assign done           = (state_q == StDone);
  assign pass           = done && (mismatch_q == '0);
  assign mismatch_cnt   = mismatch_q;
  assign first_fail_idx = first_idx_q;

endmodule
